mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory bus port between instruction fetch (IF) and the data access path in the mem stage (DM).
- Grants one requester at a time and holds the grant until the bus acknowledges.
- Fixed priority DM > IF, with an anti-starvation counter that forces an IF grant.
- Sits between the fetch/mem pipeline stages and the memory bus inside top.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  XLEN  fetch address
- if_flush  in  1  discard in-flight fetch response (branch redirect)
- if_ack  out  1  fetch response valid
- if_rdata  out  XLEN  fetch data
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store
- dm_addr  in  XLEN  data address
- dm_wdata  in  XLEN  store data
- dm_be  in  4  byte enables
- dm_ack  out  1  data response/completion
- dm_rdata  out  XLEN  load data
- bus_req  out  1  bus request (registered)
- bus_we  out  1  registered
- bus_addr  out  XLEN  registered
- bus_wdata  out  XLEN  registered
- bus_be  out  4  registered (4'b1111 for fetch)
- bus_ack  in  1  bus completion, any latency >= 1 cycle after bus_req
- bus_rdata  in  XLEN  valid with bus_ack

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM.
- Reset (next edge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0; starve_cnt=0; flush_pend=0. if_ack/dm_ack=0 because state is IDLE.
- IDLE arbitration, per cycle:
  - dm_req only -> BUSY_DM.
  - if_req only -> BUSY_IF.
  - Both requesting, starve_cnt == STARVE_MAX -> BUSY_IF and starve_cnt=0.
  - Both requesting otherwise -> BUSY_DM and starve_cnt+1.
  - Neither -> stay IDLE.
- On grant, the winner's payload is latched into the bus_* registers and bus_req=1 at the next edge.
- Any IF grant clears starve_cnt. starve_cnt saturates at STARVE_MAX.
- BUSY_x: bus_req and payload stay stable until bus_ack. On the bus_ack cycle:
  - x_ack = 1 combinationally and x_rdata = bus_rdata.
  - Next edge: state=IDLE, bus_req=0.
- Latency: request at cycle t -> bus_req at t+1 -> ack at earliest t+2. Back-to-back transactions need a 1-cycle IDLE gap; max throughput is 1 transaction per 3 cycles with a 1-cycle bus.
- if_ack/dm_ack are never asserted outside the matching BUSY state and the bus_ack cycle. if_ack and dm_ack are never both high.
- if_rdata/dm_rdata equal bus_rdata at all times; they are meaningful only with the ack.
- if_flush:
  - In BUSY_IF, sets flush_pend. The bus transaction completes normally, but if_ack is suppressed on that bus_ack.
  - flush_pend clears on the bus_ack edge.
  - if_flush on the same cycle as bus_ack in BUSY_IF also suppresses if_ack.
  - In IDLE/BUSY_DM, if_flush has no effect; the fetch stage withdraws if_req itself.
- Requesters must not change payload or drop req before ack. The arbiter uses latched values, so mid-transaction changes do not affect the bus.
- Reset mid-transaction: return to IDLE next edge and drop bus_req. The bus slave is reset by the same reset.
- A bus_ack received while in IDLE is ignored.

Decomposition:
- Shared package/include holds:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY_IF=2'd1, ST_BUSY_DM=2'd2;
  - BE_WORD=4'b1111.
- Single flat module; no sub-module needed. The starvation counter is inline.

Test Plan:
- Single fetch, if_req with if_addr=0x100, bus_ack 1 cycle after bus_req, bus_rdata=0x00000013 -> bus_req at t+1 with bus_addr=0x100 and bus_be=4'b1111; if_ack=1 with if_rdata=0x13 at t+2; back to IDLE at t+3.
- Simultaneous if_req and dm_req (store 0xDEADBEEF to 0x2000, be=4'b0011) -> DM granted first with bus_we=1 and bus_wdata=0xDEADBEEF; IF granted after dm_ack.
- dm_req held continuously, if_req held, STARVE_MAX=4 -> 4 DM transactions, then an IF grant on the 5th arbitration; starve_cnt returns to 0.
- Fetch in flight, if_flush pulsed 1 cycle after bus_req, bus_ack 3 cycles later -> if_ack stays 0; state returns to IDLE and bus_req drops.
- reset asserted while in BUSY_DM with bus_req=1 -> next edge bus_req=0, state=IDLE, starve_cnt=0; no dm_ack.
- Long bus latency (bus_ack after 10 cycles) with if_addr changed mid-transaction -> bus_addr holds the original value for all 10 cycles; exactly one ack is produced.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam int         STARVE_W = 4;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                 input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory bus signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_flush;
  logic            if_ack;
  logic [XLEN-1:0] if_rdata;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic [3:0]      dm_be;
  logic            dm_ack;
  logic [XLEN-1:0] dm_rdata;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_be;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  bus_ack, bus_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output bus_ack, bus_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus port between fetch and data access
// Fixed priority DM > IF; an anti-starvation counter forces an IF grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master mp
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [XLEN-1:0]     r_bus_addr;
  logic [XLEN-1:0]     r_bus_wdata;
  logic [3:0]          r_bus_be;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                r_flush_pend;
  logic                w_flush_nxt;
  logic                w_grant_if;
  logic                w_grant_dm;
  logic                w_if_ack;
  logic                w_dm_ack;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_flush_nxt  = r_flush_pend;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mp.dm_req && mp.if_req) begin
          if (r_starve_cnt == STARVE_LIM) begin
            w_grant_if = 1'b1;
          end else begin
            w_grant_dm   = 1'b1;
            w_starve_nxt = sat_inc(r_starve_cnt, STARVE_LIM);
          end
        end else if (mp.dm_req) begin
          w_grant_dm = 1'b1;
        end else if (mp.if_req) begin
          w_grant_if = 1'b1;
        end
        if (w_grant_if) begin
          w_state_nxt  = ST_BUSY_IF;
          w_starve_nxt = '0;
        end
        if (w_grant_dm) begin
          w_state_nxt = ST_BUSY_DM;
        end
        w_flush_nxt = 1'b0;
      end
      ST_BUSY_IF: begin
        // A redirect during the fetch only silences its response; the bus cycle still completes.
        if (mp.bus_ack) begin
          w_state_nxt = ST_IDLE;
          w_flush_nxt = 1'b0;
        end else if (mp.if_flush) begin
          w_flush_nxt = 1'b1;
        end
      end
      ST_BUSY_DM: begin
        if (mp.bus_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_flush_pend <= w_flush_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
    end else begin
      r_bus_req <= (w_state_nxt != ST_IDLE);
      if (w_grant_dm) begin
        r_bus_we    <= mp.dm_we;
        r_bus_addr  <= mp.dm_addr;
        r_bus_wdata <= mp.dm_wdata;
        r_bus_be    <= mp.dm_be;
      end else if (w_grant_if) begin
        r_bus_we    <= 1'b0;
        r_bus_addr  <= mp.if_addr;
        r_bus_wdata <= '0;
        r_bus_be    <= BE_WORD;
      end
    end
  end

  assign w_if_ack = (r_state == ST_BUSY_IF) && mp.bus_ack && !r_flush_pend && !mp.if_flush;
  assign w_dm_ack = (r_state == ST_BUSY_DM) && mp.bus_ack;

  assign mp.if_ack    = w_if_ack;
  assign mp.dm_ack    = w_dm_ack;
  assign mp.if_rdata  = mp.bus_rdata;
  assign mp.dm_rdata  = mp.bus_rdata;
  assign mp.bus_req   = r_bus_req;
  assign mp.bus_we    = r_bus_we;
  assign mp.bus_addr  = r_bus_addr;
  assign mp.bus_wdata = r_bus_wdata;
  assign mp.bus_be    = r_bus_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.XLEN(XLEN)) bif ();

  mem_port_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mp    (bif)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bif.if_req    = 1'b0;
    bif.if_addr   = '0;
    bif.if_flush  = 1'b0;
    bif.dm_req    = 1'b0;
    bif.dm_we     = 1'b0;
    bif.dm_addr   = '0;
    bif.dm_wdata  = '0;
    bif.dm_be     = '0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      bif.bus_ack = 1'b0;
      #1;
      ok = (bif.bus_req === 1'b1);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    bif.if_req = 1'b1;
    bif.dm_req = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b1;
    #1;
    checks++;
    if ({bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_be, bif.if_ack, bif.dm_ack} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h be=%b if_ack=%b dm_ack=%b exp all zero",
               bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_be, bif.if_ack, bif.dm_ack);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h100;
    #1;
    checks++;
    if (bif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_t0_bus_req got=%b exp=0", bif.bus_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_be, bif.if_ack} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b0}) begin
      failures++;
      $display("FAIL fetch_t1_bus got req=%b we=%b addr=%h be=%b if_ack=%b exp req=1 we=0 addr=100 be=1111 if_ack=0",
               bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_be, bif.if_ack);
    end
    @(negedge clk);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h13;
    #1;
    checks++;
    if ({bif.if_ack, bif.dm_ack, bif.if_rdata} !== {1'b1, 1'b0, 32'h13}) begin
      failures++;
      $display("FAIL fetch_t2_ack got if_ack=%b dm_ack=%b rdata=%h exp 1 0 00000013", bif.if_ack, bif.dm_ack, bif.if_rdata);
    end
    @(negedge clk);
    bif.bus_ack = 1'b0;
    bif.if_req  = 1'b0;
    #1;
    checks++;
    if ({bif.bus_req, bif.if_ack} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_t3_idle got req=%b if_ack=%b exp 0 0", bif.bus_req, bif.if_ack);
    end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    bif.if_req   = 1'b1;
    bif.if_addr  = 32'h200;
    bif.dm_req   = 1'b1;
    bif.dm_we    = 1'b1;
    bif.dm_addr  = 32'h2000;
    bif.dm_wdata = 32'hDEADBEEF;
    bif.dm_be    = 4'b0011;
    @(negedge clk);
    #1;
    checks++;
    if ({bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_be} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin
      failures++;
      $display("FAIL prio_dm_first got req=%b we=%b addr=%h wdata=%h be=%b exp 1 1 2000 deadbeef 0011",
               bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_be);
    end
    @(negedge clk);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h0;
    #1;
    checks++;
    if ({bif.if_ack, bif.dm_ack} !== 2'b01) begin
      failures++;
      $display("FAIL prio_dm_ack got if_ack=%b dm_ack=%b exp 0 1", bif.if_ack, bif.dm_ack);
    end
    @(negedge clk);
    bif.bus_ack = 1'b0;
    bif.dm_req  = 1'b0;
    #1;
    checks++;
    if (bif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL prio_gap got req=%b exp 0", bif.bus_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_be} !== {1'b1, 1'b0, 32'h200, 4'hF}) begin
      failures++;
      $display("FAIL prio_if_second got req=%b we=%b addr=%h be=%b exp 1 0 200 1111",
               bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_be);
    end
    @(negedge clk);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h55AA;
    #1;
    checks++;
    if ({bif.if_ack, bif.dm_ack, bif.if_rdata} !== {1'b1, 1'b0, 32'h55AA}) begin
      failures++;
      $display("FAIL prio_if_ack got if_ack=%b dm_ack=%b rdata=%h exp 1 0 000055aa", bif.if_ack, bif.dm_ack, bif.if_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starvation();
    bit          ok;
    logic [31:0] exp_addr;
    do_reset();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h400;
    bif.dm_req  = 1'b1;
    bif.dm_addr = 32'h3000;
    bif.dm_be   = 4'hF;
    for (int g = 0; g < 10; g++) begin
      exp_addr = (g % 5 == 4) ? 32'h400 : 32'h3000;
      wait_grant(ok);
      checks++;
      if (!ok || bif.bus_addr !== exp_addr) begin
        failures++;
        $display("FAIL starve_grant%0d got req=%b addr=%h exp req=1 addr=%h", g, bif.bus_req, bif.bus_addr, exp_addr);
      end
      @(negedge clk);
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = $urandom;
      #1;
      checks++;
      if ({bif.if_ack, bif.dm_ack} !== ((g % 5 == 4) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL starve_ack%0d got if_ack=%b dm_ack=%b", g, bif.if_ack, bif.dm_ack);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h180;
    @(negedge clk);
    #1;
    checks++;
    if (bif.bus_req !== 1'b1) begin
      failures++;
      $display("FAIL flush_grant got req=%b exp 1", bif.bus_req);
    end
    @(negedge clk);
    bif.if_flush = 1'b1;
    bif.if_req   = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bif.if_flush  = 1'b0;
      bif.bus_ack   = (c == 3);
      bif.bus_rdata = 32'hF00D0000 + 32'(c);
      #1;
      checks++;
      if ({bif.bus_req, bif.if_ack, bif.dm_ack} !== 3'b100) begin
        failures++;
        $display("FAIL flush_suppress%0d got req=%b if_ack=%b dm_ack=%b exp 1 0 0", c, bif.bus_req, bif.if_ack, bif.dm_ack);
      end
    end
    @(negedge clk);
    bif.bus_ack = 1'b0;
    #1;
    checks++;
    if (bif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got req=%b exp 0", bif.bus_req);
    end
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h1C0;
    wait_grant(ok);
    @(negedge clk);
    bif.bus_ack  = 1'b1;
    bif.if_flush = 1'b1;
    bif.if_req   = 1'b0;
    #1;
    checks++;
    if (!ok || bif.if_ack !== 1'b0) begin
      failures++;
      $display("FAIL flush_same_cycle got grant=%b if_ack=%b exp grant=1 if_ack=0", ok, bif.if_ack);
    end
    @(negedge clk);
    bif.bus_ack  = 1'b0;
    bif.if_flush = 1'b0;
    bif.if_req   = 1'b1;
    bif.if_addr  = 32'h1E0;
    wait_grant(ok);
    checks++;
    if (!ok || bif.bus_addr !== 32'h1E0) begin
      failures++;
      $display("FAIL flush_next_grant got req=%b addr=%h exp 1 1e0", bif.bus_req, bif.bus_addr);
    end
    @(negedge clk);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h77;
    #1;
    checks++;
    if ({bif.if_ack, bif.if_rdata} !== {1'b1, 32'h77}) begin
      failures++;
      $display("FAIL flush_next_ack got if_ack=%b rdata=%h exp 1 00000077", bif.if_ack, bif.if_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit          ok;
    logic [31:0] exp_addr;
    do_reset();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h600;
    bif.dm_req  = 1'b1;
    bif.dm_addr = 32'h7000;
    bif.dm_be   = 4'hF;
    for (int g = 0; g < 4; g++) begin
      wait_grant(ok);
      if (g < 3) begin
        @(negedge clk);
        bif.bus_ack = 1'b1;
      end
    end
    @(negedge clk);
    reset       = 1'b1;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    reset       = 1'b0;
    bif.if_req  = 1'b0;
    bif.dm_req  = 1'b0;
    bif.bus_ack = 1'b1;
    #1;
    checks++;
    if (!ok || {bif.bus_req, bif.if_ack, bif.dm_ack} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_drop got busy_before=%b req=%b if_ack=%b dm_ack=%b exp 1 0 0 0", ok, bif.bus_req, bif.if_ack, bif.dm_ack);
    end
    @(negedge clk);
    bif.bus_ack = 1'b0;
    #1;
    checks++;
    if (bif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_stray_ack got req=%b exp 0", bif.bus_req);
    end
    bif.if_req = 1'b1;
    bif.dm_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_addr = (g == 4) ? 32'h600 : 32'h7000;
      wait_grant(ok);
      checks++;
      if (!ok || bif.bus_addr !== exp_addr) begin
        failures++;
        $display("FAIL rstmid_starve%0d got req=%b addr=%h exp 1 %h", g, bif.bus_req, bif.bus_addr, exp_addr);
      end
      @(negedge clk);
      bif.bus_ack = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_long_latency();
    bit ok;
    int acks;
    do_reset();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h500;
    wait_grant(ok);
    acks = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 3) bif.if_addr = 32'hBAD0;
      if (c == 11) bif.if_req = 1'b0;
      bif.bus_ack   = (c == 10);
      bif.bus_rdata = 32'hC0DE0000 + 32'(c);
      #1;
      if (bif.if_ack === 1'b1) acks++;
      if (c <= 10) begin
        checks++;
        if (!ok || bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h500) begin
          failures++;
          $display("FAIL longlat_hold%0d got req=%b addr=%h exp 1 500", c, bif.bus_req, bif.bus_addr);
        end
      end
      if (c == 10) begin
        checks++;
        if (bif.if_rdata !== 32'hC0DE000A) begin
          failures++;
          $display("FAIL longlat_rdata got=%h exp=c0de000a", bif.if_rdata);
        end
      end
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL longlat_ack_count got=%0d exp=1", acks);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Transaction-level model: requesters hold until answered, grant rule applied per idle cycle.
  task automatic test_random();
    bit          if_pend, dm_pend, busy, flushed, fl;
    int          owner, losses, wait_cnt, lat;
    logic [31:0] ia, da, dwd, e_addr, e_wdata;
    logic        dwe, e_we, exp_if_ack, exp_dm_ack;
    logic [3:0]  dbe, e_be;
    do_reset();
    if_pend = 0; dm_pend = 0; busy = 0; flushed = 0;
    owner = 0; losses = 0; wait_cnt = 0; lat = 1;
    ia = '0; da = '0; dwd = '0; dwe = 1'b0; dbe = 4'hF;
    e_addr = '0; e_wdata = '0; e_we = 1'b0; e_be = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (busy) begin
        if ({bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_be} !== {1'b1, e_we, e_addr, e_be} ||
            (owner == 2 && bif.bus_wdata !== e_wdata)) begin
          failures++;
          $display("FAIL rand_bus cyc=%0d got req=%b we=%b addr=%h wdata=%h be=%b exp 1 %b %h %h %b",
                   cyc, bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_be, e_we, e_addr, e_wdata, e_be);
        end
      end else if (bif.bus_req !== 1'b0) begin
        failures++;
        $display("FAIL rand_bus_idle cyc=%0d got req=%b exp 0", cyc, bif.bus_req);
      end
      if (busy) begin
        wait_cnt++;
        bif.bus_ack = (wait_cnt > lat);
      end else begin
        bif.bus_ack = ($urandom_range(0, 7) == 0);
      end
      bif.bus_rdata = $urandom;
      fl = ($urandom_range(0, 15) == 0);
      if (fl) if_pend = 1'b0;
      else if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        ia      = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1'b1;
        dwe     = 1'($urandom_range(0, 1));
        da      = $urandom & 32'hFFFF_FFFC;
        dwd     = $urandom;
        dbe     = 4'($urandom_range(1, 15));
      end
      bif.if_flush = fl;
      bif.if_req   = if_pend;
      bif.if_addr  = ia;
      bif.dm_req   = dm_pend;
      bif.dm_we    = dwe;
      bif.dm_addr  = da;
      bif.dm_wdata = dwd;
      bif.dm_be    = dbe;
      exp_if_ack = busy && owner == 1 && bif.bus_ack && !flushed && !fl;
      exp_dm_ack = busy && owner == 2 && bif.bus_ack;
      #1;
      checks++;
      if ({bif.if_ack, bif.dm_ack} !== {exp_if_ack, exp_dm_ack}) begin
        failures++;
        $display("FAIL rand_ack cyc=%0d got if_ack=%b dm_ack=%b exp %b %b", cyc, bif.if_ack, bif.dm_ack, exp_if_ack, exp_dm_ack);
      end
      checks++;
      if (bif.if_rdata !== bif.bus_rdata || bif.dm_rdata !== bif.bus_rdata) begin
        failures++;
        $display("FAIL rand_rdata cyc=%0d got if=%h dm=%h exp %h", cyc, bif.if_rdata, bif.dm_rdata, bif.bus_rdata);
      end
      if (busy) begin
        if (bif.bus_ack) begin
          if (owner == 2) dm_pend = 1'b0;
          if (exp_if_ack) if_pend = 1'b0;
          busy = 1'b0; flushed = 1'b0; owner = 0;
        end else if (owner == 1 && fl) begin
          flushed = 1'b1;
        end
      end else if (if_pend || dm_pend) begin
        busy = 1'b1; wait_cnt = 0; lat = $urandom_range(1, 4);
        if (if_pend && (!dm_pend || losses == STARVE_MAX)) begin
          owner = 1; losses = 0;
          e_we = 1'b0; e_addr = ia; e_be = 4'hF;
        end else begin
          owner = 2;
          if (if_pend && losses < STARVE_MAX) losses++;
          e_we = dwe; e_addr = da; e_wdata = dwd; e_be = dbe;
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_flush();
    test_reset_mid();
    test_long_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
